// File: rtl/color_crasher_pkg.sv
// Shared types, playfield constants and DDAVER enemy-grid helpers for the
// bullet scheduler and the graphics generator.
package color_crasher_pkg;

    typedef logic [11:0] color_t;
    typedef logic [3:0]  cell_t;

    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 12;
    localparam int BSIZE     = 40;

    typedef struct packed {
        color_t color;
        cell_t  x;
        cell_t  y;
    } slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } sched_state_t;

    // Enemies sit on odd rows 1..9 and even columns 4..14.
    function automatic logic is_enemy_cell(cell_t x, cell_t y);
        return y[0] && (y <= 4'd9) && !x[0] && (x >= 4'd4) && (x <= 4'd14);
    endfunction

    function automatic logic [2:0] enemy_row(cell_t y);
        return 3'(y >> 1);
    endfunction

    function automatic logic [2:0] enemy_col(cell_t x);
        return 3'(x >> 1) - 3'd2;
    endfunction

endpackage

// File: rtl/ddaver_cell_map.sv
// Combinational map from a playfield cell to its DDAVER enemy slot.
module ddaver_cell_map
    import color_crasher_pkg::*;
(
    input  cell_t      x,
    input  cell_t      y,
    output logic       is_enemy,
    output logic [2:0] row,
    output logic [2:0] col
);

    assign is_enemy = is_enemy_cell(x, y);
    assign row      = enemy_row(y);
    assign col      = enemy_col(x);

endmodule

// File: rtl/bullet_scheduler.sv
// Frame-synchronous BulletBill slot controller: fire allocation, stepping and
// DDAVER collision. Define BULLET_SCHED_SCORE_EN to add the hit_count output.
module bullet_scheduler
    import color_crasher_pkg::*;
#(
    parameter int NUM_BULLETS     = 3,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      fire_req,
    input  logic [11:0]               fire_color,
    input  logic [3:0]                blockieee,
    output logic                      fire_ack,
    output logic                      fire_nack,
    output logic [2:0]                ddaver_rd_row,
    output logic [2:0]                ddaver_rd_col,
    input  logic [11:0]               ddaver_rd_data,
    output logic                      ddaver_clr_valid,
    output logic [2:0]                ddaver_clr_row,
    output logic [2:0]                ddaver_clr_col,
    output logic [12*NUM_BULLETS-1:0] bulletBillColor,
    output logic [4*NUM_BULLETS-1:0]  bulletBillXLoc,
    output logic [4*NUM_BULLETS-1:0]  bulletBillYLoc,
    output logic                      busy
`ifdef BULLET_SCHED_SCORE_EN
    ,
    output logic [7:0]                hit_count
`endif
);

    localparam int             IW        = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_BULLETS - 1);
    localparam logic [7:0]     STEP_WRAP = 8'(FRAMES_PER_STEP - 1);
    localparam cell_t          LAST_COL  = cell_t'(GRID_COLS - 1);

    sched_state_t  state;
    slot_t         slots [NUM_BULLETS];
    logic [IW-1:0] idx;
    logic [7:0]    step_cnt;
    logic          step_pending;
    logic          fire_lock;

    // busy mirrors the FSM state (high only in STEP) for observers.
    assign busy = (state == STEP);

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign bulletBillColor[12*g +: 12] = slots[g].color;
        assign bulletBillXLoc[4*g +: 4]    = slots[g].x;
        assign bulletBillYLoc[4*g +: 4]    = slots[g].y;
    end

    // fire_req is a level request held until fire_ack or fire_nack; after the
    // pulse it must drop for one cycle before it can be taken again.
    logic fire_take, fire_bad, free_found;
    logic [IW-1:0] free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_BULLETS - 1; k >= 0; k--) begin
            if (slots[k].color == '0) begin
                free_found = 1'b1;
                free_idx   = IW'(k);
            end
        end
    end

    assign fire_take = (state == IDLE) && fire_req && !fire_lock;
    assign fire_bad  = (fire_color == '0) || (blockieee >= cell_t'(GRID_ROWS)) || !free_found;

    slot_t      cur;
    cell_t      nx;
    logic       nx_enemy, live, at_edge, probe;
    logic [2:0] nx_row, nx_col;

    assign cur     = slots[idx];
    assign nx      = cur.x + 4'd1;
    assign live    = (cur.color != '0);
    assign at_edge = (cur.x == LAST_COL);

    ddaver_cell_map u_map (
        .x        (nx),
        .y        (cur.y),
        .is_enemy (nx_enemy),
        .row      (nx_row),
        .col      (nx_col)
    );

    assign probe         = (state == STEP) && live && !at_edge && nx_enemy;
    assign ddaver_rd_row = probe ? nx_row : 3'd0;
    assign ddaver_rd_col = probe ? nx_col : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            step_cnt         <= '0;
            step_pending     <= 1'b0;
            fire_lock        <= 1'b0;
            fire_ack         <= 1'b0;
            fire_nack        <= 1'b0;
            ddaver_clr_valid <= 1'b0;
            ddaver_clr_row   <= '0;
            ddaver_clr_col   <= '0;
            for (int k = 0; k < NUM_BULLETS; k++) slots[k] <= '0;
`ifdef BULLET_SCHED_SCORE_EN
            hit_count        <= '0;
`endif
        end else begin
            fire_ack         <= 1'b0;
            fire_nack        <= 1'b0;
            ddaver_clr_valid <= 1'b0;
            if (!fire_req) fire_lock <= 1'b0;

            case (state)
                IDLE: begin
                    if (fire_take) begin
                        fire_lock <= 1'b1;
                        if (fire_bad) begin
                            fire_nack <= 1'b1;
                        end else begin
                            slots[free_idx] <= '{color: fire_color, x: 4'd2, y: blockieee};
                            fire_ack        <= 1'b1;
                        end
                    end else if (step_pending) begin
                        step_pending <= 1'b0;
                        idx          <= '0;
                        state        <= STEP;
                    end
                end
                STEP: begin
                    if (live) begin
                        if (at_edge) begin
                            slots[idx].color <= '0;
                        end else if (nx_enemy && ddaver_rd_data != '0) begin
                            slots[idx].color <= '0;
                            if (ddaver_rd_data == cur.color) begin
                                ddaver_clr_valid <= 1'b1;
                                ddaver_clr_row   <= nx_row;
                                ddaver_clr_col   <= nx_col;
`ifdef BULLET_SCHED_SCORE_EN
                                if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
`endif
                            end
                        end else begin
                            slots[idx].x <= nx;
                        end
                    end
                    if (idx == LAST_IDX) state <= IDLE;
                    else                 idx   <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a tick landing on the consume cycle re-arms.
            if (frame_tick) begin
                if (step_cnt == STEP_WRAP) begin
                    step_cnt     <= '0;
                    step_pending <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 8'd1;
                end
            end
        end
    end

endmodule
